// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - register map, status bit positions and decode helper for io_bus_responder
package io_bus_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_1000;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_RXPOP  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CYCLES = 8'h10;
  localparam logic [7:0] OFF_CLRERR = 8'h14;

  localparam int ST_TX_EMPTY     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_TX_OVF       = 4;
  localparam int ST_RX_OVF       = 5;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 16;

  typedef enum logic [2:0] {
    REG_TXDATA,
    REG_RXDATA,
    REG_RXPOP,
    REG_STATUS,
    REG_CYCLES,
    REG_CLRERR,
    REG_NONE
  } reg_sel_e;

  // Word index only; the byte lane bits of the address never reach the decoder.
  function automatic reg_sel_e decode_offset(input logic [5:0] word);
    case ({word, 2'b00})
      OFF_TXDATA: return REG_TXDATA;
      OFF_RXDATA: return REG_RXDATA;
      OFF_RXPOP:  return REG_RXPOP;
      OFF_STATUS: return REG_STATUS;
      OFF_CYCLES: return REG_CYCLES;
      OFF_CLRERR: return REG_CLRERR;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO with wrapping pointers and a separate occupancy count
module byte_fifo #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/io_bus_responder.sv
// rtl/io_bus_responder.sv - memory-mapped TX/RX byte FIFOs, status, error flags and cycle counter
module io_bus_responder
  import io_bus_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [31:0] BASE  = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  reg_sel_e      w_sel;
  logic          w_wr_tx;
  logic          w_wr_rxpop;
  logic          w_wr_cycles;
  logic          w_wr_clrerr;
  logic          w_tx_pop;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic [7:0]    w_rx_head;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_rx_count;
  logic          w_tx_ovf_set;
  logic          w_rx_ovf_set;
  logic [31:0]   w_status;
  logic          w_unused_adr;
  logic          r_tx_ovf;
  logic          r_rx_ovf;
  logic [31:0]   r_cycles;

  assign hit   = (DataAdr[31:8] == BASE[31:8]);
  assign w_sel = hit ? decode_offset(DataAdr[7:2]) : REG_NONE;
  assign w_unused_adr = ^DataAdr[1:0];

  assign w_wr_tx     = MemWrite && (w_sel == REG_TXDATA);
  assign w_wr_rxpop  = MemWrite && (w_sel == REG_RXPOP);
  assign w_wr_cycles = MemWrite && (w_sel == REG_CYCLES);
  assign w_wr_clrerr = MemWrite && (w_sel == REG_CLRERR);

  assign tx_valid = !w_tx_empty;
  assign w_tx_pop = tx_valid && tx_ready;
  assign rx_ready = !w_rx_full;

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wr_tx),
    .pop   (w_tx_pop),
    .din   (WriteData[7:0]),
    .dout  (tx_data),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  // The FIFO also takes rx_valid while full if RXPOP frees a slot the same cycle.
  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (w_wr_rxpop),
    .din   (rx_data),
    .dout  (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

  assign w_tx_ovf_set = w_wr_tx && w_tx_full && !w_tx_pop;
  assign w_rx_ovf_set = rx_valid && w_rx_full && !w_wr_rxpop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_cycles <= '0;
    end else begin
      if (w_tx_ovf_set)                     r_tx_ovf <= 1'b1;
      else if (w_wr_clrerr && WriteData[0]) r_tx_ovf <= 1'b0;
      if (w_rx_ovf_set)                     r_rx_ovf <= 1'b1;
      else if (w_wr_clrerr && WriteData[1]) r_rx_ovf <= 1'b0;
      r_cycles <= w_wr_cycles ? WriteData : r_cycles + 32'd1;
    end
  end

  always_comb begin
    w_status                            = '0;
    w_status[ST_TX_EMPTY]               = w_tx_empty;
    w_status[ST_TX_FULL]                = w_tx_full;
    w_status[ST_RX_EMPTY]               = w_rx_empty;
    w_status[ST_RX_FULL]                = w_rx_full;
    w_status[ST_TX_OVF]                 = r_tx_ovf;
    w_status[ST_RX_OVF]                 = r_rx_ovf;
    w_status[ST_TX_COUNT_LSB +: 8]      = 8'(w_tx_count);
    w_status[ST_RX_COUNT_LSB +: 8]      = 8'(w_rx_count);
  end

  always_comb begin
    ReadData = '0;
    case (w_sel)
      REG_RXDATA: ReadData = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      REG_STATUS: ReadData = w_status;
      REG_CYCLES: ReadData = r_cycles;
      default:    ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// tb/tb_io_bus_responder.sv - directed self-checking bench for io_bus_responder
module tb_io_bus_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [7:0]  O_TX = 8'h00, O_RXD = 8'h04, O_POP = 8'h08;
  localparam logic [7:0]  O_ST = 8'h0C, O_CYC = 8'h10, O_CLR = 8'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  io_bus_responder #(.DEPTH(8), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  always #5 clk = ~clk;

  // Bus tasks start and end just after a falling edge.
  task automatic bus_write(input logic [7:0] off, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = BASE | {24'd0, off};
    WriteData = data;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] data);
    DataAdr = BASE | {24'd0, off};
    #1;
    data = ReadData;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
    bus_read(O_CYC, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_cycles: got %h expected 0", v); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0000_0005) begin n_fail++; $display("FAIL reset_status: got %h expected 00000005", v); end
    @(negedge clk);
  endtask

  task automatic test_tx_overflow();
    logic [31:0] v;
    logic [7:0]  got[$];
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(O_TX, 32'h41 + i);
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0000_0816) begin n_fail++; $display("FAIL tx_full_status: got %h expected 00000816", v); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) got.push_back(tx_data);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    n_checks++; if (got.size() !== 8) begin n_fail++; $display("FAIL tx_drain_len: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 8'(8'h41 + i)) begin n_fail++; $display("FAIL tx_drain_byte%0d: got %h expected %h", i, got[i], 8'(8'h41 + i)); end
    end
    bus_write(O_CLR, 32'h1);
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0000_0005) begin n_fail++; $display("FAIL tx_clrerr_status: got %h expected 00000005", v); end
    @(negedge clk);
  endtask

  task automatic test_rx_pop();
    logic [31:0] v;
    rx_send(8'hA0); rx_send(8'hA1); rx_send(8'hA2);
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0003_0001) begin n_fail++; $display("FAIL rx3_status: got %h expected 00030001", v); end
    bus_read(O_RXD, v);
    n_checks++; if (v !== 32'h0000_00A0) begin n_fail++; $display("FAIL rx_head0: got %h expected 000000a0", v); end
    @(negedge clk);
    bus_write(O_POP, 32'd0);
    bus_read(O_RXD, v);
    n_checks++; if (v !== 32'h0000_00A1) begin n_fail++; $display("FAIL rx_head1: got %h expected 000000a1", v); end
    @(negedge clk);
    bus_write(O_POP, 32'd0);
    bus_write(O_POP, 32'd0);
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0000_0005) begin n_fail++; $display("FAIL rx_drained_status: got %h expected 00000005", v); end
    bus_read(O_RXD, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rx_empty_read: got %h expected 0", v); end
    @(negedge clk);
    bus_write(O_POP, 32'd0);
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0000_0005) begin n_fail++; $display("FAIL rx_pop_empty: got %h expected 00000005", v); end
    @(negedge clk);
  endtask

  task automatic test_rx_full_pop();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) rx_send(8'h10 + 8'(i));
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready); end
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0008_0009) begin n_fail++; $display("FAIL rx_full_status: got %h expected 00080009", v); end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h18;
    bus_write(O_POP, 32'd0);
    rx_valid = 1'b0;
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0008_0009) begin n_fail++; $display("FAIL rx_push_pop_full: got %h expected 00080009", v); end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h99;
    bus_write(O_CLR, 32'h2);
    rx_valid = 1'b0;
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0008_0029) begin n_fail++; $display("FAIL rx_ovf_set_wins: got %h expected 00080029", v); end
    @(negedge clk);
    bus_write(O_CLR, 32'h2);
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0008_0009) begin n_fail++; $display("FAIL rx_ovf_clear: got %h expected 00080009", v); end
    @(negedge clk);
    for (int i = 0; i < 7; i++) bus_write(O_POP, 32'd0);
    bus_read(O_RXD, v);
    n_checks++; if (v !== 32'h0000_0018) begin n_fail++; $display("FAIL rx_last_byte: got %h expected 00000018", v); end
    @(negedge clk);
    bus_write(O_POP, 32'd0);
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0000_0005) begin n_fail++; $display("FAIL rx_final_empty: got %h expected 00000005", v); end
    @(negedge clk);
  endtask

  task automatic test_cycles();
    logic [31:0] v;
    bus_write(O_CYC, 32'hFFFF_FFFE);
    bus_read(O_CYC, v);
    n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cycles_load: got %h expected fffffffe", v); end
    @(negedge clk);
    bus_read(O_CYC, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycles_inc: got %h expected ffffffff", v); end
    @(negedge clk);
    bus_read(O_CYC, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL cycles_wrap: got %h expected 00000000", v); end
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    logic [31:0] v;
    MemWrite = 1'b1; DataAdr = 32'h0000_2000; WriteData = 32'h41;
    #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b expected 0", hit); end
    n_checks++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL miss_rdata: got %h expected 0", ReadData); end
    @(negedge clk);
    MemWrite = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL miss_no_push: got %b expected 0", tx_valid); end
    bus_write(O_ST, 32'hFFFF_FFFF);
    bus_write(8'h18, 32'hFFFF_FFFF);
    bus_read(8'h18, v);
    n_checks++; if (v !== 32'd0 || hit !== 1'b1) begin n_fail++; $display("FAIL unmapped_off: got %h hit %b expected 0 hit 1", v, hit); end
    bus_read(8'h0F, v);
    n_checks++; if (v !== 32'h0000_0005) begin n_fail++; $display("FAIL ro_write_status: got %h expected 00000005", v); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    tx_ready = 1'b0;
    bus_write(O_TX, 32'h55);
    bus_write(O_TX, 32'h66);
    rx_send(8'h77);
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_tx_valid: got %b expected 1", tx_valid); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL async_rx_ready: got %b expected 1", rx_ready); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(O_ST, v);
    n_checks++; if (v !== 32'h0000_0005) begin n_fail++; $display("FAIL post_reset_status: got %h expected 00000005", v); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_tx_overflow();
    test_rx_pop();
    test_rx_full_pop();
    test_cycles();
    test_unmapped();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
